// File: rtl/bist_pkg.sv
// Shared constants for the BIST output-response analyser: FSM encoding,
// MISR width and the feedback tap mask of x^8+x^6+x^5+x^4+1.
package bist_pkg;

    localparam int MISR_W = 8;

    // Feedback from bit 7 is XORed into bits 0, 4, 5 and 6.
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'h71;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_t;

endpackage

// File: rtl/misr_8.sv
// 8-bit internal-XOR MISR compacting a 2-bit response (d[0]=sum, d[1]=carry)
// per enabled cycle; load has priority over en.
module misr_8
    import bist_pkg::*;
#(
    parameter logic [MISR_W-1:0] INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [MISR_W-1:0] seed,
    input  logic [1:0]        d,
    output logic [MISR_W-1:0] q
);

    logic [MISR_W-1:0] next;

    always_comb begin
        next = {q[MISR_W-2:0], 1'b0} ^ (q[MISR_W-1] ? MISR_TAPS : '0)
             ^ {{(MISR_W-2){1'b0}}, d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= INIT;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= next;
        end
    end

endmodule

// File: rtl/bist_misr_ora.sv
// BIST output-response analyser: compacts PAT_CNT sum/carry beats into a MISR
// and flags pass/fail against a golden signature.
module bist_misr_ora
    import bist_pkg::*;
#(
    parameter int                PAT_CNT = 8,
    parameter logic [MISR_W-1:0] SEED    = 8'h00,
    parameter logic [MISR_W-1:0] GOLDEN  = 8'h47
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic              sum_in,
    input  logic              carry_in,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [MISR_W-1:0] signature
);

    localparam int CNT_W = $clog2(PAT_CNT + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PAT_CNT - 1);

    bist_state_t      state;
    logic [CNT_W-1:0] beat_cnt;
    logic             accept;
    logic             launch;

    assign accept = in_valid && in_ready;
    assign launch = start && ((state == ST_IDLE) || (state == ST_DONE));

    misr_8 #(
        .INIT (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (launch),
        .en    (accept),
        .seed  (SEED),
        .d     ({carry_in, sum_in}),
        .q     (signature)
    );

    // All status outputs are registered alongside the state so they change
    // exactly on the transition edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        beat_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        fail     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= ST_CHECK;
                            in_ready <= 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (signature == GOLDEN);
                    fail  <= (signature != GOLDEN);
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_misr_ora.sv
// Self-checking bench for bist_misr_ora: directed and random runs checked
// against a GF(2) polynomial model of the signature.
module tb_bist_misr_ora;

    localparam logic [7:0] SEED   = 8'h00;
    localparam logic [7:0] GOLDEN = 8'h47;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       sum_in = 1'b0;
    logic       carry_in = 1'b0;
    logic       in_ready, busy, done, pass, fail;
    logic [7:0] signature;

    int assertCount = 0;
    int failCount = 0;

    bist_misr_ora #(
        .PAT_CNT (8),
        .SEED    (SEED),
        .GOLDEN  (GOLDEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail      (fail),
        .signature (signature)
    );

    always #5 clk = ~clk;

    // Signature as a polynomial: s' = (s*x + carry*x + sum) mod (x^8+x^6+x^5+x^4+1).
    function automatic logic [7:0] misrModel(input logic [7:0] s, input logic sum, input logic carry);
        logic [8:0] t;
        t = {s, 1'b0} ^ {7'b0, carry, sum};
        if (t[8]) t = t ^ 9'h171;
        return t[7:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkIdleZeros(input string tag);
        checkOutput({tag, "_in_ready"}, {7'b0, in_ready}, 8'h00);
        checkOutput({tag, "_busy"}, {7'b0, busy}, 8'h00);
        checkOutput({tag, "_done"}, {7'b0, done}, 8'h00);
        checkOutput({tag, "_pass"}, {7'b0, pass}, 8'h00);
        checkOutput({tag, "_fail"}, {7'b0, fail}, 8'h00);
        checkOutput({tag, "_sig"}, signature, SEED);
    endtask

    // One run: start, nBeats beats (optionally with stalls and a stray start
    // pulse), then verdict checks when the full pattern was delivered.
    task automatic applyStimulus(input string tag, input logic [7:0] sums, input logic [7:0] carries,
                                 input bit stalls, input bit strayStart, input int nBeats,
                                 output logic [7:0] model);
        model = SEED;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        checkOutput({tag, "_start_busy"}, {7'b0, busy}, 8'h01);
        checkOutput({tag, "_start_ready"}, {7'b0, in_ready}, 8'h01);
        checkOutput({tag, "_start_done"}, {7'b0, done, pass, fail}, 8'h00);
        checkOutput({tag, "_start_sig"}, signature, SEED);
        for (int i = 0; i < nBeats; i++) begin
            if (stalls) begin
                in_valid = 1'b0;
                sum_in   = $urandom_range(0, 1);
                carry_in = $urandom_range(0, 1);
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    stepCycle();
                    checkOutput({tag, "_gap_sig"}, signature, model);
                end
            end
            start    = strayStart && (i == 3);
            in_valid = 1'b1;
            sum_in   = sums[i];
            carry_in = carries[i];
            stepCycle();
            start    = 1'b0;
            model    = misrModel(model, sums[i], carries[i]);
            checkOutput($sformatf("%s_beat%0d_sig", tag, i + 1), signature, model);
        end
        if (nBeats == 8) begin
            // in_valid stays high through CHECK and must be ignored there.
            checkOutput({tag, "_check_ready"}, {7'b0, in_ready}, 8'h00);
            checkOutput({tag, "_check_busy"}, {7'b0, busy, done}, 8'h02);
            stepCycle();
            in_valid = 1'b0;
            checkOutput({tag, "_done_sig"}, signature, model);
            checkOutput({tag, "_done_flags"}, {5'b0, busy, done, 1'b0},  8'h02);
            checkOutput({tag, "_verdict"}, {6'b0, pass, fail},
                        (model == GOLDEN) ? 8'h02 : 8'h01);
        end
    endtask

    initial begin
        logic [7:0] sig;
        logic [7:0] held;

        $display("[TB] start");
        #1;
        checkIdleZeros("reset");
        stepCycle();
        rst_n = 1'b1;
        in_valid = 1'b1;
        sum_in = 1'b1;
        carry_in = 1'b1;
        stepCycle();
        stepCycle();
        in_valid = 1'b0;
        checkIdleZeros("idle_after_reset");

        applyStimulus("golden", 8'h96, 8'hE8, 1'b0, 1'b0, 8, sig);
        checkOutput("golden_const", signature, 8'h47);
        checkOutput("golden_pass", {6'b0, pass, fail}, 8'h02);

        held = signature;
        in_valid = 1'b1;
        sum_in = 1'b1;
        carry_in = 1'b0;
        stepCycle();
        stepCycle();
        in_valid = 1'b0;
        checkOutput("done_hold_sig", signature, held);
        checkOutput("done_hold_flags", {5'b0, done, pass, fail}, 8'h06);

        applyStimulus("stuck0", 8'h96, 8'h00, 1'b0, 1'b0, 8, sig);
        checkOutput("stuck0_const", signature, 8'h69);
        checkOutput("stuck0_fail", {6'b0, pass, fail}, 8'h01);

        applyStimulus("stall", 8'h96, 8'hE8, 1'b1, 1'b1, 8, sig);
        checkOutput("stall_const", signature, 8'h47);

        applyStimulus("midreset", 8'h96, 8'hE8, 1'b0, 1'b0, 4, sig);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkIdleZeros("midreset_now");
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle();
        checkIdleZeros("midreset_idle");
        applyStimulus("rerun", 8'h96, 8'hE8, 1'b0, 1'b0, 8, sig);
        checkOutput("rerun_const", signature, 8'h47);

        for (int r = 0; r < 4; r++) begin
            applyStimulus($sformatf("rand%0d", r), 8'($urandom), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'b1, 8, sig);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
